round_robin_arbiter_16: RTL

//   Shares one resource (bus port, shared unit) among 16 requesters using rotating

---
 rtl/round_robin_arbiter_16.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/round_robin_arbiter_16.sv
// Round-robin arbiter for 16 requesters sharing one resource.
// A winner is picked by a downward priority search that starts just below the
// previous winner, so the last owner always ends up lowest priority. Ownership
// lasts until the owner signals Done_In, drops its request, or holds for
// MAX_HOLD consecutive cycles. Every output is registered.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no owner; arbitrate over Req_In every cycle
//   ST_OWNED   | Grant_Id owns the resource; watch Done_In, owner Req, timer
//   ST_RELEASE | one-cycle gap after a release; arbitrate like ST_IDLE
module round_robin_arbiter_16 #(
  parameter int unsigned MAX_HOLD   = 255,
  parameter int unsigned HOLD_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] Req_In,
  input  logic        Done_In,
  output logic [15:0] Grant_Out,
  output logic [3:0]  Grant_Id,
  output logic        Grant_Valid,
  output logic        Timeout_Out
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWNED   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            last_q, last_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d;
  logic [15:0]           grant_q, grant_d;
  logic [3:0]            id_q, id_d;
  logic                  valid_q, valid_d;
  logic                  timeout_q, timeout_d;

  logic                  win_found;
  logic [3:0]            win_id;
  logic [3:0]            search_idx;
  logic                  arbitrating;
  logic                  grant_start;
  logic                  owner_release;
  logic                  hold_expired;

  // Rotating priority search: Last-1 downward, wrapping 0 -> 15, ending at Last.
  always_comb begin
    win_found  = 1'b0;
    win_id     = last_q;
    search_idx = '0;
    for (int k = 1; k <= 16; k++) begin
      search_idx = last_q - 4'(k);
      if (!win_found && Req_In[search_idx]) begin
        win_found = 1'b1;
        win_id    = search_idx;
      end
    end
  end

  // Release conditions; a voluntary release takes precedence over the timer.
  always_comb begin
    arbitrating   = (state_q == ST_IDLE) || (state_q == ST_RELEASE);
    grant_start   = arbitrating && win_found;
    owner_release = Done_In || !Req_In[id_q];
    hold_expired  = (MAX_HOLD != 0) && (hold_q == HOLD_WIDTH'(MAX_HOLD));
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RELEASE: begin
        state_d = win_found ? ST_OWNED : ST_IDLE;
      end
      ST_OWNED: begin
        if (owner_release || hold_expired) begin
          state_d = ST_RELEASE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Next values for the registered outputs, last winner and hold counter.
  always_comb begin
    last_d    = last_q;
    id_d      = id_q;
    hold_d    = '0;
    timeout_d = 1'b0;

    if (grant_start) begin
      last_d = win_id;
      id_d   = win_id;
      hold_d = HOLD_WIDTH'(1);
    end else if (state_q == ST_OWNED && state_d == ST_OWNED) begin
      // Saturate so an unlimited hold never wraps back into a small count.
      hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_WIDTH'(1);
    end

    if (state_q == ST_OWNED && !owner_release && hold_expired) begin
      timeout_d = 1'b1;
    end

    valid_d = (state_d == ST_OWNED);
    grant_d = valid_d ? (16'h0001 << id_d) : 16'h0000;
  end

  // Output, last-winner and hold-counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_q    <= '0;
      hold_q    <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign Grant_Out   = grant_q;
  assign Grant_Id    = id_q;
  assign Grant_Valid = valid_q;
  assign Timeout_Out = timeout_q;

  // Output invariants: grant matches the id, and a timeout never overlaps ownership.
  a_grant_onehot : assert property (@(posedge clock) disable iff (!reset_n)
    Grant_Out == (Grant_Valid ? (16'h0001 << Grant_Id) : 16'h0000));
  a_timeout_gap : assert property (@(posedge clock) disable iff (!reset_n)
    Timeout_Out |-> !Grant_Valid);

endmodule
